// File: rtl/des_subkey_gen_if.sv
// Handshake bundle between the DES key schedule and the round datapath.
// The master drives the request and key_ready; the slave (key schedule) drives status and keys.
interface des_subkey_gen_if;
    logic        start;
    logic        mode;
    logic [1:28] c0;
    logic [1:28] d0;
    logic        busy;
    logic        key_valid;
    logic        key_ready;
    logic [1:48] key_out;
    logic [4:0]  key_idx;
    logic        done;

    modport master (
        output start, mode, c0, d0, key_ready,
        input  busy, key_valid, key_out, key_idx, done
    );

    modport slave (
        input  start, mode, c0, d0, key_ready,
        output busy, key_valid, key_out, key_idx, done
    );
endinterface

// File: rtl/des_subkey_gen.sv
// DES round-subkey generator: streams K1..K16 (encrypt) or K16..K1 (decrypt) from C0/D0,
// rotating C/D in place so no key storage is needed.
module des_subkey_gen #(
    parameter bit KEY_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    des_subkey_gen_if.slave   kif
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

    state_e      state_q, state_d;
    logic [1:28] c_q, c_d;
    logic [1:28] d_q, d_d;
    logic        mode_q, mode_d;
    logic [4:0]  idx_q, idx_d;
    logic [1:56] cd;
    logic [1:48] key_pc2;

    function automatic logic [1:0] shift_of(input logic [4:0] r);
        return (r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [1:28] rotl(input logic [1:28] v, input logic [1:0] n);
        return (n == 2'd1) ? {v[2:28], v[1]} : {v[3:28], v[1:2]};
    endfunction

    function automatic logic [1:28] rotr(input logic [1:28] v, input logic [1:0] n);
        return (n == 2'd1) ? {v[28], v[1:27]} : {v[27:28], v[1:26]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
        end
    end

    // C/D always hold the halves for the key currently presented, so the
    // encrypt path pre-rotates by shift(1) at start and decrypt starts unrotated.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (kif.start) begin
                    state_d = RUN;
                    mode_d  = kif.mode;
                    if (kif.mode) begin
                        c_d   = kif.c0;
                        d_d   = kif.d0;
                        idx_d = 5'd16;
                    end else begin
                        c_d   = rotl(kif.c0, 2'd1);
                        d_d   = rotl(kif.d0, 2'd1);
                        idx_d = 5'd1;
                    end
                end
            end
            RUN: begin
                if (kif.key_ready) begin
                    if (!mode_q) begin
                        if (idx_q == 5'd16) begin
                            state_d = FIN;
                        end else begin
                            idx_d = idx_q + 5'd1;
                            c_d   = rotl(c_q, shift_of(idx_q + 5'd1));
                            d_d   = rotl(d_q, shift_of(idx_q + 5'd1));
                        end
                    end else begin
                        if (idx_q == 5'd1) begin
                            state_d = FIN;
                        end else begin
                            idx_d = idx_q - 5'd1;
                            c_d   = rotr(c_q, shift_of(idx_q));
                            d_d   = rotr(d_q, shift_of(idx_q));
                        end
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cd = {c_q, d_q};

    assign key_pc2 = {cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
                      cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
                      cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
                      cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
                      cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
                      cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
                      cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
                      cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};

    assign kif.busy      = (state_q != IDLE);
    assign kif.key_valid = (state_q == RUN);
    assign kif.done      = (state_q == FIN);
    assign kif.key_idx   = idx_q;
    assign kif.key_out   = (KEY_CLEAR && state_q != RUN) ? '0 : key_pc2;

endmodule

// File: tb/tb_des_subkey_gen.sv
// Directed bench for des_subkey_gen using the FIPS example key; instance A clears key_out
// when idle, instance B holds it.
module tb_des_subkey_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, mode, key_ready;
    logic [1:28] c0, d0;

    int n_cmp = 0;
    int n_err = 0;
    logic [47:0] kexp [1:16];

    localparam logic [1:28] FC0 = 28'hF0CCAAF;
    localparam logic [1:28] FD0 = 28'h556678F;

    always #5 clk = ~clk;

    des_subkey_gen_if ifa();
    des_subkey_gen_if ifb();

    assign ifa.start = start;  assign ifb.start = start;
    assign ifa.mode  = mode;   assign ifb.mode  = mode;
    assign ifa.c0    = c0;     assign ifb.c0    = c0;
    assign ifa.d0    = d0;     assign ifb.d0    = d0;
    assign ifa.key_ready = key_ready;
    assign ifb.key_ready = key_ready;

    des_subkey_gen #(.KEY_CLEAR(1'b1)) dut_a (.clk(clk), .rst(rst), .kif(ifa.slave));
    des_subkey_gen #(.KEY_CLEAR(1'b0)) dut_b (.clk(clk), .rst(rst), .kif(ifb.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic m, input logic [1:28] c, input logic [1:28] d);
        start = 1'b1; mode = m; c0 = c; d0 = d;
        tick();
        start = 1'b0; mode = 1'bx; c0 = 'x; d0 = 'x;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; key_ready = 1'b0; mode = 1'bx; c0 = 'x; d0 = 'x;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        n_cmp++;
        if (ifa.key_valid !== 1'b0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got v=%b b=%b d=%b want 0/0/0", ifa.key_valid, ifa.busy, ifa.done);
        end
        n_cmp++;
        if (ifa.key_out !== 48'h0 || ifb.key_out !== 48'h0 || ifa.key_idx !== 5'd0) begin
            n_err++;
            $display("FAIL reset_key got a=%h b=%h idx=%0d want 0/0/0", ifa.key_out, ifb.key_out, ifa.key_idx);
        end
    endtask

    task automatic test_encrypt();
        key_ready = 1'b1;
        start_run(1'b0, FC0, FD0);
        for (int i = 1; i <= 16; i++) begin
            n_cmp++;
            if (ifa.key_valid !== 1'b1 || ifa.busy !== 1'b1 || ifa.key_idx !== 5'(i)
                || ifa.key_out !== kexp[i] || ifb.key_out !== kexp[i]) begin
                n_err++;
                $display("FAIL enc_key%0d got v=%b idx=%0d a=%h b=%h want idx=%0d key=%h",
                         i, ifa.key_valid, ifa.key_idx, ifa.key_out, ifb.key_out, i, kexp[i]);
            end
            tick();
        end
        n_cmp++;
        if (ifa.done !== 1'b1 || ifa.key_valid !== 1'b0 || ifa.busy !== 1'b1) begin
            n_err++;
            $display("FAIL enc_done got d=%b v=%b b=%b want 1/0/1", ifa.done, ifa.key_valid, ifa.busy);
        end
        n_cmp++;
        if (ifa.key_out !== 48'h0 || ifb.key_out !== 48'hCB3D8B0E17F5) begin
            n_err++;
            $display("FAIL enc_keyclear got a=%h b=%h want 0/cb3d8b0e17f5", ifa.key_out, ifb.key_out);
        end
        tick();
        n_cmp++;
        if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
            n_err++;
            $display("FAIL enc_idle got b=%b d=%b want 0/0", ifa.busy, ifa.done);
        end
    endtask

    task automatic test_decrypt();
        key_ready = 1'b1;
        start_run(1'b1, FC0, FD0);
        for (int i = 16; i >= 1; i--) begin
            n_cmp++;
            if (ifa.key_valid !== 1'b1 || ifa.key_idx !== 5'(i)
                || ifa.key_out !== kexp[i] || ifb.key_out !== kexp[i]) begin
                n_err++;
                $display("FAIL dec_key%0d got v=%b idx=%0d a=%h b=%h want idx=%0d key=%h",
                         i, ifa.key_valid, ifa.key_idx, ifa.key_out, ifb.key_out, i, kexp[i]);
            end
            tick();
        end
        n_cmp++;
        if (ifa.done !== 1'b1 || ifa.key_valid !== 1'b0 || ifb.key_out !== kexp[1]) begin
            n_err++;
            $display("FAIL dec_done got d=%b v=%b b=%h want 1/0/%h", ifa.done, ifa.key_valid, ifb.key_out, kexp[1]);
        end
        tick();
        n_cmp++;
        if (ifa.busy !== 1'b0) begin
            n_err++;
            $display("FAIL dec_idle got busy=%b want 0", ifa.busy);
        end
    endtask

    task automatic test_backpressure();
        int  exp_i = 1;
        int  stall = 0;
        int  cyc   = 0;
        bit  seen  = 1'b0;
        key_ready = 1'b0;
        start_run(1'b0, FC0, FD0);
        while (!seen && cyc < 300) begin
            if (ifa.done === 1'b1) begin
                seen = 1'b1;
                n_cmp++;
                if (exp_i != 17) begin
                    n_err++;
                    $display("FAIL bp_done got handshakes=%0d want 16", exp_i - 1);
                end
            end else if (ifa.key_valid === 1'b1 && exp_i <= 16) begin
                n_cmp++;
                if (ifa.key_idx !== 5'(exp_i) || ifa.key_out !== kexp[exp_i]) begin
                    n_err++;
                    $display("FAIL bp_key got idx=%0d key=%h want idx=%0d key=%h",
                             ifa.key_idx, ifa.key_out, exp_i, kexp[exp_i]);
                end
                if (exp_i == 3 && stall < 5) begin
                    key_ready = 1'b0;
                    stall++;
                end else begin
                    key_ready = ($urandom_range(0, 2) != 0);
                end
                if (key_ready) exp_i++;
            end else begin
                n_cmp++;
                n_err++;
                $display("FAIL bp_valid got v=%b idx=%0d want v=1 idx=%0d", ifa.key_valid, ifa.key_idx, exp_i);
                key_ready = 1'b1;
            end
            tick();
            cyc++;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL bp_timeout got no done want done within 300 cycles");
        end
        key_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        key_ready = 1'b1;
        start_run(1'b0, FC0, FD0);
        for (int i = 1; i <= 16; i++) begin
            n_cmp++;
            if (ifa.key_idx !== 5'(i) || ifa.key_out !== kexp[i]) begin
                n_err++;
                $display("FAIL ign_key%0d got idx=%0d key=%h want key=%h", i, ifa.key_idx, ifa.key_out, kexp[i]);
            end
            if (i == 7) begin
                start = 1'b1; mode = 1'b1; c0 = 28'hFFFFFFF; d0 = 28'h0000001;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        // In FIN: this start must be ignored
        start = 1'b1; mode = 1'b0; c0 = 28'h0; d0 = 28'h0;
        n_cmp++;
        if (ifa.done !== 1'b1) begin
            n_err++;
            $display("FAIL ign_done got done=%b want 1", ifa.done);
        end
        tick();
        n_cmp++;
        if (ifa.busy !== 1'b0 || ifa.key_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fin_start got b=%b v=%b want 0/0", ifa.busy, ifa.key_valid);
        end
        tick();
        start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            n_cmp++;
            if (ifa.key_valid !== 1'b1 || ifa.key_idx !== 5'(i) || ifa.key_out !== 48'h0) begin
                n_err++;
                $display("FAIL zero_key%0d got v=%b idx=%0d key=%h want 1/%0d/0",
                         i, ifa.key_valid, ifa.key_idx, ifa.key_out, i);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_rst_mid();
        key_ready = 1'b1;
        start_run(1'b0, FC0, FD0);
        for (int i = 1; i < 9; i++) tick();
        n_cmp++;
        if (ifa.key_idx !== 5'd9 || ifa.key_out !== kexp[9]) begin
            n_err++;
            $display("FAIL rst_pre got idx=%0d key=%h want 9/%h", ifa.key_idx, ifa.key_out, kexp[9]);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (ifa.key_valid !== 1'b0 || ifa.key_out !== 48'h0 || ifb.key_out !== 48'h0
            || ifa.key_idx !== 5'd0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid got v=%b a=%h b=%h idx=%0d busy=%b done=%b want all 0",
                     ifa.key_valid, ifa.key_out, ifb.key_out, ifa.key_idx, ifa.busy, ifa.done);
        end
        start = 1'b1; mode = 1'b0; c0 = FC0; d0 = FD0;
        tick();
        n_cmp++;
        if (ifa.key_valid !== 1'b0 || ifa.key_out !== 48'h0 || ifa.key_idx !== 5'd0 || ifa.busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_start got v=%b key=%h idx=%0d busy=%b want all 0",
                     ifa.key_valid, ifa.key_out, ifa.key_idx, ifa.busy);
        end
        rst = 1'b0;
        tick();
        start = 1'b0;
        n_cmp++;
        if (ifa.key_valid !== 1'b1 || ifa.key_idx !== 5'd1 || ifa.key_out !== 48'h1B02EFFC7072) begin
            n_err++;
            $display("FAIL rst_fresh got v=%b idx=%0d key=%h want 1/1/1b02effc7072",
                     ifa.key_valid, ifa.key_idx, ifa.key_out);
        end
        for (int i = 0; i < 18; i++) tick();
        n_cmp++;
        if (ifa.busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_end got busy=%b want 0", ifa.busy);
        end
    endtask

    initial begin
        kexp[1]  = 48'h1B02EFFC7072; kexp[2]  = 48'h79AED9DBC9E5;
        kexp[3]  = 48'h55FC8A42CF99; kexp[4]  = 48'h72ADD6DB351D;
        kexp[5]  = 48'h7CEC07EB53A8; kexp[6]  = 48'h63A53E507B2F;
        kexp[7]  = 48'hEC84B7F618BC; kexp[8]  = 48'hF78A3AC13BFB;
        kexp[9]  = 48'hE0DBEBEDE781; kexp[10] = 48'hB1F347BA464F;
        kexp[11] = 48'h215FD3DED386; kexp[12] = 48'h7571F59467E9;
        kexp[13] = 48'h97C5D1FABA41; kexp[14] = 48'h5F43B7F2E73A;
        kexp[15] = 48'hBF918D3D3F0A; kexp[16] = 48'hCB3D8B0E17F5;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
